// File: rtl/syn_fifo_prog_pkg.sv
// Shared constants and helpers for the programmable synchronous FIFO.
// Holds the default widths and the depth helper, so that the FIFO and its
// users all size things the same way.
package syn_fifo_prog_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 3;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/ram_dp_ar_aw.sv
// Dual-port RAM: one synchronous write port and one asynchronous read port.
// Ports:
//   i_clk             write clock
//   i_we              write enable
//   i_waddr, i_wdata  write address and data
//   i_raddr           read address
//   o_rdata           read data (combinational from i_raddr)
// The array has no reset, so its contents survive a controller reset.
module ram_dp_ar_aw #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/syn_fifo_prog.sv
// Synchronous FIFO with a chip-select plus enable handshake, programmable
// almost-full/almost-empty thresholds, an occupancy count, a standard or
// first-word-fall-through read port, and sticky overflow/underflow flags.
// Ports:
//   i_clk, i_rst_n                clock, synchronous active-low reset
//   i_wr_cs, i_wr_en, i_data_in   write request and data
//   i_rd_cs, i_rd_en, o_data_out  read request and data
//   i_af_thresh, i_ae_thresh      almost-full / almost-empty thresholds
//   i_clr_err                     clears the sticky error flags
//   o_count                       occupancy, 0..DEPTH
//   o_empty, o_full               occupancy decodes
//   o_almost_empty, o_almost_full threshold decodes
//   o_overflow, o_underflow       sticky rejected-request flags
module syn_fifo_prog
  import syn_fifo_prog_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_cs,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_rd_cs,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_data_out,
  input  logic [ADDR_WIDTH:0]   i_af_thresh,
  input  logic [ADDR_WIDTH:0]   i_ae_thresh,
  input  logic                  i_clr_err,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_empty,
  output logic                  o_almost_full,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  typedef logic [ADDR_WIDTH:0] count_t;

  localparam count_t DEPTH = count_t'(fifo_depth(ADDR_WIDTH));

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  count_t                count;
  logic                  overflow;
  logic                  underflow;
  logic [DATA_WIDTH-1:0] rd_data;

  logic wr_req;
  logic rd_req;
  logic wr_acc;
  logic rd_acc;

  assign wr_req = i_wr_cs & i_wr_en;
  assign rd_req = i_rd_cs & i_rd_en;
  assign rd_acc = rd_req & ~o_empty;
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_acc = wr_req & (~o_full | rd_acc);

  // Gating with reset drops an in-flight write without touching stored words.
  ram_dp_ar_aw #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (wr_acc & i_rst_n),
    .i_waddr (wr_ptr),
    .i_wdata (i_data_in),
    .i_raddr (rd_ptr),
    .o_rdata (rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count <= count + count_t'(1);
      else if (rd_acc && !wr_acc) count <= count - count_t'(1);
      // A new error in the same cycle as a clear wins.
      overflow  <= (wr_req & ~wr_acc) | (overflow  & ~i_clr_err);
      underflow <= (rd_req & ~rd_acc) | (underflow & ~i_clr_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign o_data_out = o_empty ? '0 : rd_data;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          data_q <= '0;
        end else if (rd_acc) begin
          data_q <= rd_data;
        end
      end
      assign o_data_out = data_q;
    end
  endgenerate

  assign o_count        = count;
  assign o_empty        = (count == '0);
  assign o_full         = (count == DEPTH);
  assign o_almost_empty = (count <= i_ae_thresh);
  assign o_almost_full  = (count >= i_af_thresh);
  assign o_overflow     = overflow;
  assign o_underflow    = underflow;

endmodule

// File: tb/tb_syn_fifo_prog.sv
module tb_syn_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_cs = 1'b0, wr_en = 1'b0, rd_cs = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [3:0] af_thresh = 4'd6, ae_thresh = 4'd1;

  logic [7:0] dout0, dout1;
  logic [3:0] cnt0, cnt1;
  logic       emp0, ful0, ae0, af0, ovf0, unf0;
  logic       emp1, ful1, ae1, af1, ovf1, unf1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  syn_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_cs(wr_cs), .i_wr_en(wr_en), .i_data_in(data_in),
    .i_rd_cs(rd_cs), .i_rd_en(rd_en), .o_data_out(dout0), .i_af_thresh(af_thresh),
    .i_ae_thresh(ae_thresh), .i_clr_err(clr_err), .o_count(cnt0), .o_empty(emp0),
    .o_full(ful0), .o_almost_empty(ae0), .o_almost_full(af0), .o_overflow(ovf0),
    .o_underflow(unf0));

  syn_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_cs(wr_cs), .i_wr_en(wr_en), .i_data_in(data_in),
    .i_rd_cs(rd_cs), .i_rd_en(rd_en), .o_data_out(dout1), .i_af_thresh(af_thresh),
    .i_ae_thresh(ae_thresh), .i_clr_err(clr_err), .o_count(cnt1), .o_empty(emp1),
    .o_full(ful1), .o_almost_empty(ae1), .o_almost_full(af1), .o_overflow(ovf1),
    .o_underflow(unf1));

  // flags packed as {empty, full, almost_empty, almost_full, overflow, underflow}
  typedef struct {
    logic       rst_n;
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] din;
    logic [3:0] exp_cnt;
    logic [7:0] exp_dout;
    logic [5:0] exp_flags;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic w, logic rd, logic c, logic [7:0] d,
                              logic [3:0] ec, logic [7:0] ed, logic [5:0] ef);
    vec_t v;
    v.rst_n = r; v.wr = w; v.rd = rd; v.clr = c; v.din = d;
    v.exp_cnt = ec; v.exp_dout = ed; v.exp_flags = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic c,
                      input logic [7:0] d);
    rst_n = r; wr_cs = w; wr_en = w; rd_cs = rd; rd_en = rd; clr_err = c; data_in = d;
    @(posedge clk);
    #1;
    rst_n = 1'b1; wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  function automatic logic [5:0] flags0();
    return {emp0, ful0, ae0, af0, ovf0, unf0};
  endfunction

  initial begin
    // reset and idle
    vecs.push_back(mk(0, 1, 0, 0, 8'hEE, 4'd0, 8'h00, 6'b101000));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 4'd0, 8'h00, 6'b101000));
    // fill with 0x10..0x17
    vecs.push_back(mk(1, 1, 0, 0, 8'h10, 4'd1, 8'h00, 6'b001000));
    vecs.push_back(mk(1, 1, 0, 0, 8'h11, 4'd2, 8'h00, 6'b000000));
    vecs.push_back(mk(1, 1, 0, 0, 8'h12, 4'd3, 8'h00, 6'b000000));
    vecs.push_back(mk(1, 1, 0, 0, 8'h13, 4'd4, 8'h00, 6'b000000));
    vecs.push_back(mk(1, 1, 0, 0, 8'h14, 4'd5, 8'h00, 6'b000000));
    vecs.push_back(mk(1, 1, 0, 0, 8'h15, 4'd6, 8'h00, 6'b000100));
    vecs.push_back(mk(1, 1, 0, 0, 8'h16, 4'd7, 8'h00, 6'b000100));
    vecs.push_back(mk(1, 1, 0, 0, 8'h17, 4'd8, 8'h00, 6'b010100));
    // extra write while full is rejected
    vecs.push_back(mk(1, 1, 0, 0, 8'h99, 4'd8, 8'h00, 6'b010110));
    // drain
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 4'd7, 8'h10, 6'b000110));
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 4'd6, 8'h11, 6'b000110));
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 4'd5, 8'h12, 6'b000010));
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 4'd4, 8'h13, 6'b000010));
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 4'd3, 8'h14, 6'b000010));
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 4'd2, 8'h15, 6'b000010));
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 4'd1, 8'h16, 6'b001010));
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 4'd0, 8'h17, 6'b101010));
    // read while empty is rejected, data holds
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 4'd0, 8'h17, 6'b101011));
    // clear both flags
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 4'd0, 8'h17, 6'b101000));
    // clear together with a fresh underflow: the set wins
    vecs.push_back(mk(1, 0, 1, 1, 8'h00, 4'd0, 8'h17, 6'b101001));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 4'd0, 8'h17, 6'b101000));

    #2;
    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
      chk($sformatf("vec%0d count", i), 32'(cnt0), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d dout", i), 32'(dout0), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d flags", i), 32'(flags0()), 32'(vecs[i].exp_flags));
    end

    // full FIFO with simultaneous read and write: pointers wrap, count holds
    step(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 8'h20 + 8'(i));
    chk("full_before_rw", 32'(ful0), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 0, 8'hAA);
      chk($sformatf("rw%0d count", i), 32'(cnt0), 32'd8);
      chk($sformatf("rw%0d dout", i), 32'(dout0), 32'(8'h20 + 8'(i)));
    end
    chk("rw_no_overflow", 32'(ovf0), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1, 0, 8'h00);
      chk($sformatf("wrap_drain%0d", i), 32'(dout0), 32'hAA);
    end
    chk("wrap_empty", 32'(emp0), 32'd1);

    // FWFT: word visible after the write edge without a read
    step(0, 0, 0, 0, 8'h00);
    chk("fwft_reset_dout", 32'(dout1), 32'd0);
    step(1, 1, 0, 0, 8'h5C);
    chk("fwft_show", 32'(dout1), 32'h5C);
    step(1, 0, 0, 0, 8'h00);
    chk("fwft_hold", 32'(dout1), 32'h5C);
    chk("fwft_count", 32'(cnt1), 32'd1);
    step(1, 0, 1, 0, 8'h00);
    chk("fwft_pop_empty", 32'(emp1), 32'd1);
    chk("fwft_pop_dout", 32'(dout1), 32'd0);

    // read+write on empty: write taken, read rejected
    step(1, 1, 1, 0, 8'h3E);
    chk("empty_rw_count", 32'(cnt1), 32'd1);
    chk("empty_rw_unf", 32'(unf1), 32'd1);
    chk("empty_rw_dout", 32'(dout1), 32'h3E);

    // reset in the middle of writing
    step(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 8'h30 + 8'(i));
    chk("pre_rst_count", 32'(cnt0), 32'd5);
    step(0, 1, 1, 0, 8'h77);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_flags", 32'(flags0()), 32'b101000);
    chk("rst_fwft_dout", 32'(dout1), 32'd0);
    step(1, 1, 0, 0, 8'h44);
    chk("post_rst_fwft", 32'(dout1), 32'h44);
    step(1, 0, 1, 0, 8'h00);
    chk("post_rst_std", 32'(dout0), 32'h44);
    chk("post_rst_empty", 32'(emp0), 32'd1);

    // thresholds act combinationally
    af_thresh = 4'd0;
    #1;
    chk("af_thresh0", 32'(af0), 32'd1);
    ae_thresh = 4'd0;
    af_thresh = 4'd6;
    #1;
    chk("ae_thresh0", 32'(ae0), 32'd1);
    step(1, 1, 0, 0, 8'h01);
    chk("ae_thresh0_cnt1", 32'(ae0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
